// File: rtl/bus_switch_if.sv
// CPU data port and slave-side signals of the bus switch.
// Modport slave is the switch itself; master is the CPU plus slaves.
interface bus_switch_if #(
    parameter int NSLAVE = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
);
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic                 m_read;
    logic                 m_write;
    logic                 m_instr;
    logic                 m_busy;
    logic                 m_ready;
    logic [DW-1:0]        m_rdata;
    logic                 m_err;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata;
    logic [NSLAVE-1:0]    s_read;
    logic [NSLAVE-1:0]    s_write;
    logic [NSLAVE-1:0]    s_read_done;
    logic [NSLAVE*DW-1:0] s_rdata;
    logic [NSLAVE-1:0]    s_ready;

    modport slave (
        input  m_addr, m_wdata, m_read, m_write, m_instr,
        input  s_rdata, s_ready,
        output m_busy, m_ready, m_rdata, m_err,
        output s_addr, s_wdata, s_read, s_write, s_read_done
    );

    modport master (
        output m_addr, m_wdata, m_read, m_write, m_instr,
        output s_rdata, s_ready,
        input  m_busy, m_ready, m_rdata, m_err,
        input  s_addr, s_wdata, s_read, s_write, s_read_done
    );
endinterface

// File: rtl/bus_switch.sv
// Registered MMIO switch: region decode, one-cycle strobe, wait for ready.
// Define BUS_TIMEOUT_EN to add the WAIT-state timeout (m_err on expiry).
module bus_switch #(
    parameter int                  NSLAVE      = 4,
    parameter int                  AW          = 16,
    parameter int                  DW          = 16,
    parameter logic [NSLAVE*AW-1:0] REGION_BASE = '0,
    parameter logic [NSLAVE*AW-1:0] REGION_MASK = '0,
    parameter int                  TIMEOUT     = 255
) (
    input  logic        clki,
    input  logic        rst_in,
    bus_switch_if.slave bus
);
    localparam int SW = $clog2(NSLAVE);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_switch: TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     sel, sel_dec;
    logic              op_wr;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rdata_q;
    logic              ready_q;
    logic              err_q;
    logic [NSLAVE-1:0] done_q;
    logic [NSLAVE-1:0] rd_stb, wr_stb;
    logic [DW-1:0]     rdata_sel;
    logic              req, rdy_sel, done_ok, to_hit;

    // ready_q doubles as the one-cycle hold-off after a completion
    assign req       = (bus.m_read | bus.m_write) & ~ready_q;
    assign rdy_sel   = bus.s_ready[sel];
    assign rdata_sel = bus.s_rdata[sel*DW +: DW];
    assign done_ok   = (state == WAIT) & rdy_sel;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt;

    assign to_hit = (state == WAIT) & ~rdy_sel
                  & (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clki) begin
        if (!rst_in)
            cnt <= '0;
        else if (state != WAIT)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Lowest matching region wins, so scan from the top down
    always_comb begin
        sel_dec = SW'(NSLAVE - 1);
        if (!bus.m_instr) begin
            for (int i = NSLAVE - 2; i >= 0; i--) begin
                if ((bus.m_addr & REGION_MASK[i*AW +: AW]) ==
                    (REGION_BASE[i*AW +: AW] & REGION_MASK[i*AW +: AW]))
                    sel_dec = SW'(i);
            end
        end
    end

    always_ff @(posedge clki) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done_ok || to_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_stb = '0;
        wr_stb = '0;
        if (state == ISSUE) begin
            if (op_wr)
                wr_stb[sel] = 1'b1;
            else
                rd_stb[sel] = 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (!rst_in) begin
            sel     <= '0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
            if (state == IDLE && req) begin
                sel     <= sel_dec;
                op_wr   <= bus.m_write;
                addr_q  <= bus.m_addr;
                wdata_q <= bus.m_wdata;
            end
            if (done_ok) begin
                ready_q <= 1'b1;
                if (!op_wr) begin
                    rdata_q     <= rdata_sel;
                    done_q[sel] <= 1'b1;
                end
            end else if (to_hit) begin
                ready_q <= 1'b1;
                err_q   <= 1'b1;
                rdata_q <= '1;
            end
        end
    end

    assign bus.m_busy      = (state != IDLE);
    assign bus.m_ready     = ready_q;
    assign bus.m_rdata     = rdata_q;
    assign bus.m_err       = err_q;
    assign bus.s_addr      = addr_q;
    assign bus.s_wdata     = wdata_q;
    assign bus.s_read      = rd_stb;
    assign bus.s_write     = wr_stb;
    assign bus.s_read_done = done_q;
endmodule

// File: tb/tb_bus_switch.sv
// Scoreboard bench for bus_switch: driver queues expected strobes and
// completions, a negedge monitor pops and compares them.
module tb_bus_switch;
    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [15:0] addr;
        logic [15:0] wdata;
    } stb_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic [3:0]  done;
    } cpl_t;

`ifdef BUS_TIMEOUT_EN
    localparam int LOWC = 6;
`else
    localparam int LOWC = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    stb_t sq[$];
    cpl_t cq[$];
    stb_t es;
    cpl_t ec;

    always #5 clk = ~clk;

    bus_switch_if #(.NSLAVE(4), .AW(16), .DW(16)) bus ();

    bus_switch #(
        .NSLAVE     (4),
        .AW         (16),
        .DW         (16),
        .REGION_BASE({16'h0000, 16'h0000, 16'h1000, 16'h0000}),
        .REGION_MASK({16'h0000, 16'hF000, 16'hF000, 16'hFFFF}),
        .TIMEOUT    (8)
    ) dut (
        .clki  (clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (|bus.s_read || |bus.s_write) begin
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL strobe: unexpected r=%b w=%b",
                             bus.s_read, bus.s_write);
                end else begin
                    es = sq.pop_front();
                    chk("strobe", {24'd0, bus.s_write, bus.s_read},
                        es.wr ? {24'd0, es.sel, 4'd0}
                              : {24'd0, 4'd0, es.sel});
                    chk("s_addr", {16'd0, bus.s_addr}, {16'd0, es.addr});
                    if (es.wr)
                        chk("s_wdata", {16'd0, bus.s_wdata},
                            {16'd0, es.wdata});
                end
            end
            if (bus.m_ready) begin
                if (cq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL m_ready: unexpected completion");
                end else begin
                    ec = cq.pop_front();
                    chk("m_rdata", {16'd0, bus.m_rdata}, {16'd0, ec.rdata});
                    chk("m_err", {31'd0, bus.m_err}, {31'd0, ec.err});
                    chk("s_read_done", {28'd0, bus.s_read_done},
                        {28'd0, ec.done});
                end
            end else if (|bus.s_read_done) begin
                tests++;
                fails++;
                $display("FAIL s_read_done: pulse %b without m_ready",
                         bus.s_read_done);
            end
        end
    end

    task automatic push(input logic wr, input logic [3:0] sel,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] rexp, input logic err);
        stb_t s;
        cpl_t c;
        s.wr = wr; s.sel = sel; s.addr = a; s.wdata = wd;
        sq.push_back(s);
        c.rdata = rexp;
        c.err   = err;
        c.done  = (wr || err) ? 4'd0 : sel;
        cq.push_back(c);
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] wd,
                         input logic rd, input logic wr, input logic ins);
        @(negedge clk);
        bus.m_addr  = a;
        bus.m_wdata = wd;
        bus.m_read  = rd;
        bus.m_write = wr;
        bus.m_instr = ins;
        @(posedge clk);
        #1;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_instr = 1'b0;
    endtask

    // Returns negedges from the request edge until m_ready is seen
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.m_ready) break;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_ready: no m_ready within 100 cycles");
        end
    endtask

    task automatic access(input logic [15:0] a, input logic [15:0] wd,
                          input logic rd, input logic wr, input logic ins,
                          input logic [3:0] sel, input logic [15:0] rexp);
        int n;
        push(wr, sel, a, wd, rexp, 1'b0);
        drive(a, wd, rd, wr, ins);
        wait_ready(n);
        chk("latency", n - 1, 2);
    endtask

    initial begin
        int n;
        int busy_cnt;
        int rdy_cnt;
        rst_n       = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_instr = 1'b0;
        bus.s_ready = 4'b1111;
        bus.s_rdata = {16'h1111, 16'h2C2C, 16'h1B1B, 16'h00A5};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.m_busy}, 0);
        chk("rst_ready", {31'd0, bus.m_ready}, 0);
        chk("rst_err", {31'd0, bus.m_err}, 0);
        chk("rst_rdata", {16'd0, bus.m_rdata}, 0);
        chk("rst_strobes", {24'd0, bus.s_read, bus.s_write}, 0);
        chk("rst_done", {28'd0, bus.s_read_done}, 0);
        chk("rst_saddr", {16'd0, bus.s_addr}, 0);
        chk("rst_swdata", {16'd0, bus.s_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        access(16'h0000, 16'h0000, 1, 0, 0, 4'b0001, 16'h00A5);
        access(16'h1040, 16'hBEEF, 0, 1, 0, 4'b0010, 16'h00A5);
        access(16'h0007, 16'h0000, 1, 0, 0, 4'b0100, 16'h2C2C);
        access(16'h5000, 16'h0000, 1, 0, 0, 4'b1000, 16'h1111);
        access(16'h0000, 16'h0000, 1, 0, 1, 4'b1000, 16'h1111);
        access(16'h0000, 16'h1357, 1, 1, 0, 4'b0001, 16'h1111);

        // Slow default slave: ready low for LOWC WAIT cycles
        bus.s_ready[3] = 1'b0;
        push(1'b0, 4'b1000, 16'h5000, 16'h0000, 16'h1111, 1'b0);
        drive(16'h5000, 16'h0000, 1, 0, 0);
        busy_cnt = 0;
        rdy_cnt  = 0;
        for (int k = 0; k < LOWC + 8; k++) begin
            @(negedge clk);
            if (bus.m_busy) busy_cnt++;
            if (bus.m_ready) rdy_cnt++;
            if (k == LOWC + 1) bus.s_ready[3] = 1'b1;
        end
        chk("slow_busy_cycles", busy_cnt, LOWC + 2);
        chk("slow_ready_count", rdy_cnt, 1);

`ifdef BUS_TIMEOUT_EN
        bus.s_ready[1] = 1'b0;
        push(1'b0, 4'b0010, 16'h1000, 16'h0000, 16'hFFFF, 1'b1);
        drive(16'h1000, 16'h0000, 1, 0, 0);
        wait_ready(n);
        chk("timeout_latency", n, 10);
        @(negedge clk);
        bus.s_ready[1] = 1'b1;
`endif

        // Reset while stuck in WAIT: strobe expected, completion not
        bus.s_ready[3] = 1'b0;
        begin
            stb_t s;
            s.wr = 1'b0; s.sel = 4'b1000; s.addr = 16'h5000; s.wdata = '0;
            sq.push_back(s);
        end
        drive(16'h5000, 16'h0000, 1, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wait_busy", {31'd0, bus.m_busy}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("wrst_busy", {31'd0, bus.m_busy}, 0);
        chk("wrst_ready", {31'd0, bus.m_ready}, 0);
        chk("wrst_rdata", {16'd0, bus.m_rdata}, 0);
        chk("wrst_strobes", {24'd0, bus.s_read, bus.s_write}, 0);
        chk("wrst_saddr", {16'd0, bus.s_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.s_ready[3] = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {31'd0, bus.m_busy}, 0);
        access(16'h0000, 16'h0000, 1, 0, 0, 4'b0001, 16'h00A5);

        repeat (3) @(negedge clk);
        chk("strobe_queue_empty", sq.size(), 0);
        chk("cpl_queue_empty", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
